// File: rtl/tx_queue_arb.sv
// tx_queue_arb: two-source packet arbiter driving a 64-bit MAC transmit port, with truncation of over-long packets.
// Build macro TXARB_STRICT_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module tx_queue_arb #(
   parameter int MAX_BEATS = 1200
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25,
   input  logic [63:0] q0_data,
   input  logic        q0_val,
   input  logic        q0_sop,
   input  logic        q0_eop,
   input  logic [2:0]  q0_mod,
   output logic        q0_full,
   input  logic [63:0] q1_data,
   input  logic        q1_val,
   input  logic        q1_sop,
   input  logic        q1_eop,
   input  logic [2:0]  q1_mod,
   output logic        q1_full,
   output logic [63:0] pkt_tx_data,
   output logic        pkt_tx_val,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   output logic [2:0]  pkt_tx_mod,
   input  logic        pkt_tx_full,
   output logic        trunc_pulse,
   output logic        grant_idx,
   output logic        busy
);
   // state | meaning
   // IDLE  | no grant; both sources back-pressured
   // GRANT | forwarding the packet of port g to the MAC
   // DRAIN | packet of port g was truncated; its remaining beats are accepted and dropped up to eop
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

   state_t      state_q, state_d;
   logic        g_q, g_d;
   logic        lp_q, lp_d;
   logic [15:0] cnt_q, cnt_d;
   logic [63:0] tx_data_q, tx_data_d;
   logic        tx_val_q, tx_val_d;
   logic        tx_sop_q, tx_sop_d;
   logic        tx_eop_q, tx_eop_d;
   logic [2:0]  tx_mod_q, tx_mod_d;
   logic        trunc_q, trunc_d;

   logic        elig0, elig1, any_elig, other_elig;
   logic        pick, chain_ok;
   logic        active, xfer, last_beat;
   logic        sel_val, sel_sop, sel_eop;
   logic [2:0]  sel_mod;
   logic [63:0] sel_data;

   assign elig0      = q0_val & q0_sop;
   assign elig1      = q1_val & q1_sop;
   assign any_elig   = elig0 | elig1;
   assign other_elig = g_q ? elig0 : elig1;

`ifdef TXARB_STRICT_PRIO_EN
   // Back-to-back handoff only toward port 0, so port 1 can never starve port 0 through chaining.
   assign pick     = ~elig0;
   assign chain_ok = g_q;
`else
   assign pick     = (elig0 & elig1) ? ~lp_q : elig1;
   assign chain_ok = 1'b1;
`endif

   assign active  = (state_q != IDLE);
   assign q0_full = ~(active & ~g_q & ~pkt_tx_full);
   assign q1_full = ~(active &  g_q & ~pkt_tx_full);

   assign sel_val  = g_q ? q1_val  : q0_val;
   assign sel_sop  = g_q ? q1_sop  : q0_sop;
   assign sel_eop  = g_q ? q1_eop  : q0_eop;
   assign sel_mod  = g_q ? q1_mod  : q0_mod;
   assign sel_data = g_q ? q1_data : q0_data;

   assign xfer      = active & ~pkt_tx_full & sel_val;
   assign last_beat = (({1'b0, cnt_q} + 17'd1) == {1'b0, MAX_B});

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      lp_d      = lp_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      tx_mod_d  = tx_mod_q;
      tx_val_d  = 1'b0;
      tx_sop_d  = 1'b0;
      tx_eop_d  = 1'b0;
      trunc_d   = 1'b0;

      if (xfer && (cnt_q != MAX_B)) begin
         cnt_d = cnt_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (any_elig && !pkt_tx_full) begin
               state_d = GRANT;
               g_d     = pick;
               lp_d    = pick;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               tx_val_d  = 1'b1;
               tx_data_d = sel_data;
               tx_sop_d  = sel_sop;
               tx_eop_d  = sel_eop;
               tx_mod_d  = sel_mod;
               if (sel_eop) begin
                  if (other_elig && chain_ok) begin
                     g_d   = ~g_q;
                     lp_d  = ~g_q;
                     cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (last_beat) begin
                  tx_eop_d = 1'b1;
                  tx_mod_d = 3'd0;
                  trunc_d  = 1'b1;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (xfer && sel_eop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         state_q   <= IDLE;
         g_q       <= 1'b0;
         lp_q      <= 1'b1;
         cnt_q     <= '0;
         tx_data_q <= '0;
         tx_val_q  <= 1'b0;
         tx_sop_q  <= 1'b0;
         tx_eop_q  <= 1'b0;
         tx_mod_q  <= '0;
         trunc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         lp_q      <= lp_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_val_q  <= tx_val_d;
         tx_sop_q  <= tx_sop_d;
         tx_eop_q  <= tx_eop_d;
         tx_mod_q  <= tx_mod_d;
         trunc_q   <= trunc_d;
      end
   end

   assign pkt_tx_data = tx_data_q;
   assign pkt_tx_val  = tx_val_q;
   assign pkt_tx_sop  = tx_sop_q;
   assign pkt_tx_eop  = tx_eop_q;
   assign pkt_tx_mod  = tx_mod_q;
   assign trunc_pulse = trunc_q;
   assign grant_idx   = g_q;
   assign busy        = active;

endmodule

// File: tb/tb_tx_queue_arb.sv
// tb_tx_queue_arb: cycle vector table for arbitration/stall/truncation/reset corners, then randomized
// traffic scored at packet level against per-port expected output queues.
module tb_tx_queue_arb;
   localparam int MB = 4;

   logic        clk_156m25 = 1'b0;
   logic        reset_156m25;
   logic [63:0] q0_data, q1_data;
   logic        q0_val, q0_sop, q0_eop, q1_val, q1_sop, q1_eop;
   logic [2:0]  q0_mod, q1_mod;
   logic        q0_full, q1_full;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        pkt_tx_full;
   logic        trunc_pulse, grant_idx, busy;

   always #5 clk_156m25 = ~clk_156m25;

   tx_queue_arb #(.MAX_BEATS(MB)) dut (
      .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
      .q0_data(q0_data), .q0_val(q0_val), .q0_sop(q0_sop), .q0_eop(q0_eop), .q0_mod(q0_mod), .q0_full(q0_full),
      .q1_data(q1_data), .q1_val(q1_val), .q1_sop(q1_sop), .q1_eop(q1_eop), .q1_mod(q1_mod), .q1_full(q1_full),
      .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
      .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full), .trunc_pulse(trunc_pulse),
      .grant_idx(grant_idx), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // inputs: rst v0 s0 e0 v1 s1 e1 ptf ; expected: f0 f1 busy g val sop eop tr src
   typedef struct {
      logic rst, v0, s0, e0, v1, s1, e1, ptf;
      logic f0, f1, busy, g, val, sop, eop, tr, src;
   } vec_t;

   function automatic vec_t mkv(input logic [7:0] i, input logic [8:0] o);
      vec_t r;
      {r.rst, r.v0, r.s0, r.e0, r.v1, r.s1, r.e1, r.ptf} = i;
      {r.f0, r.f1, r.busy, r.g, r.val, r.sop, r.eop, r.tr, r.src} = o;
      return r;
   endfunction

   typedef struct {
      logic [63:0] data;
      logic        sop, eop;
      logic [2:0]  mod;
      logic        tr;
   } beat_t;

   beat_t src0[$], src1[$], exp0[$], exp1[$];
   int    accepted = 0, outs = 0, dropped = 0, serial = 0;
   logic  cur_port = 1'b0;
   logic  x0 = 1'b0, x1 = 1'b0;

   task automatic gen_pkt(input int p, input int sn);
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
         beat_t x;
         beat_t y;
         x.data = {p[0], sn[14:0], b[7:0], 8'h00, $urandom()};
         x.sop  = (b == 0);
         x.eop  = (b == len - 1);
         x.mod  = 3'($urandom_range(0, 7));
         x.tr   = 1'b0;
         if (p == 0) src0.push_back(x); else src1.push_back(x);
         if (b < MB) begin
            y = x;
            if (b == MB - 1 && len > MB) begin
               y.eop = 1'b1;
               y.mod = 3'd0;
               y.tr  = 1'b1;
            end
            if (p == 0) exp0.push_back(y); else exp1.push_back(y);
         end
      end
      if (len > MB) dropped += len - MB;
   endtask

   task automatic drive_srcs(input bit gen_en);
      if (gen_en && src0.size() == 0 && $urandom_range(0, 2) == 0) begin
         gen_pkt(0, serial);
         serial++;
      end
      if (gen_en && src1.size() == 0 && $urandom_range(0, 2) == 0) begin
         gen_pkt(1, serial);
         serial++;
      end
      q0_val = (src0.size() != 0) && ($urandom_range(0, 4) != 0);
      q1_val = (src1.size() != 0) && ($urandom_range(0, 4) != 0);
      if (src0.size() != 0) begin
         q0_data = src0[0].data; q0_sop = src0[0].sop; q0_eop = src0[0].eop; q0_mod = src0[0].mod;
      end
      if (src1.size() != 0) begin
         q1_data = src1[0].data; q1_sop = src1[0].sop; q1_eop = src1[0].eop; q1_mod = src1[0].mod;
      end
   endtask

   task automatic check_out();
      beat_t e;
      chk("one_grant", {63'd0, (~q0_full & ~q1_full)}, 64'd0);
      if (pkt_tx_val) begin
         outs++;
         if (pkt_tx_sop) cur_port = pkt_tx_data[63];
         if ((cur_port == 1'b0 && exp0.size() == 0) || (cur_port == 1'b1 && exp1.size() == 0)) begin
            chk("unexpected_beat", {63'd0, pkt_tx_val}, 64'd0);
         end else begin
            e = (cur_port == 1'b0) ? exp0.pop_front() : exp1.pop_front();
            chk("rnd_data", pkt_tx_data, e.data);
            chk("rnd_sop", {63'd0, pkt_tx_sop}, {63'd0, e.sop});
            chk("rnd_eop", {63'd0, pkt_tx_eop}, {63'd0, e.eop});
            chk("rnd_mod", {61'd0, pkt_tx_mod}, {61'd0, e.mod});
            chk("rnd_trunc", {63'd0, trunc_pulse}, {63'd0, e.tr});
         end
      end else begin
         chk("rnd_trunc_idle", {63'd0, trunc_pulse}, 64'd0);
      end
   endtask

   task automatic idle_inputs();
      q0_val = 0; q0_sop = 0; q0_eop = 0; q0_mod = 0; q0_data = 0;
      q1_val = 0; q1_sop = 0; q1_eop = 0; q1_mod = 0; q1_data = 0;
      pkt_tx_full = 0;
   endtask

   vec_t tbl[$];

   initial begin
      reset_156m25 = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk_156m25);
      @(negedge clk_156m25);
      chk("rst_val", {63'd0, pkt_tx_val}, 64'd0);
      chk("rst_sop", {63'd0, pkt_tx_sop}, 64'd0);
      chk("rst_eop", {63'd0, pkt_tx_eop}, 64'd0);
      chk("rst_data", pkt_tx_data, 64'd0);
      chk("rst_mod", {61'd0, pkt_tx_mod}, 64'd0);
      chk("rst_trunc", {63'd0, trunc_pulse}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_grant", {63'd0, grant_idx}, 64'd0);
      chk("rst_q0_full", {63'd0, q0_full}, 64'd1);
      chk("rst_q1_full", {63'd0, q1_full}, 64'd1);

`ifndef TXARB_STRICT_PRIO_EN
      tbl.push_back(mkv(8'b0_000_000_0, 9'b110000000)); // 0 idle
      tbl.push_back(mkv(8'b0_000_100_0, 9'b110000000)); // 1 q1 val without sop
      tbl.push_back(mkv(8'b0_000_100_0, 9'b110000000));
      tbl.push_back(mkv(8'b0_110_110_0, 9'b110000000)); // 3 both sop
      tbl.push_back(mkv(8'b0_110_110_0, 9'b011000000)); // 4 tie -> q0
      tbl.push_back(mkv(8'b0_100_110_0, 9'b011011000));
      tbl.push_back(mkv(8'b0_101_110_0, 9'b011010000));
      tbl.push_back(mkv(8'b0_110_110_0, 9'b101110100)); // 7 chained to q1
      tbl.push_back(mkv(8'b0_110_100_0, 9'b101111001));
      tbl.push_back(mkv(8'b0_110_101_0, 9'b101110001));
      tbl.push_back(mkv(8'b0_110_000_0, 9'b011010101)); // 10 chained to q0
      tbl.push_back(mkv(8'b0_100_000_1, 9'b111011000)); // 11-15 MAC full
      tbl.push_back(mkv(8'b0_100_000_1, 9'b111000000));
      tbl.push_back(mkv(8'b0_100_000_1, 9'b111000000));
      tbl.push_back(mkv(8'b0_100_000_1, 9'b111000000));
      tbl.push_back(mkv(8'b0_100_000_1, 9'b111000000));
      tbl.push_back(mkv(8'b0_100_000_0, 9'b011000000)); // 16 resume
      tbl.push_back(mkv(8'b0_101_000_0, 9'b011010000));
      tbl.push_back(mkv(8'b0_000_111_0, 9'b110010100)); // 18 q1 single beat
      tbl.push_back(mkv(8'b0_111_111_0, 9'b101100000));
      tbl.push_back(mkv(8'b0_111_000_0, 9'b011011101)); // 20 q0 single after q1 single
      tbl.push_back(mkv(8'b0_000_110_0, 9'b110011100)); // 21 q1 long packet
      tbl.push_back(mkv(8'b0_000_110_0, 9'b101100000));
      tbl.push_back(mkv(8'b0_000_100_0, 9'b101111001));
      tbl.push_back(mkv(8'b0_000_110_0, 9'b101110001)); // 24 sop mid-packet
      tbl.push_back(mkv(8'b0_000_100_0, 9'b101111001));
      tbl.push_back(mkv(8'b0_000_100_0, 9'b101110111)); // 26 truncated beat 4
      tbl.push_back(mkv(8'b0_000_100_0, 9'b101100000));
      tbl.push_back(mkv(8'b0_000_101_0, 9'b101100000));
      tbl.push_back(mkv(8'b0_110_000_0, 9'b110000000)); // 29 back to idle
      tbl.push_back(mkv(8'b0_110_000_0, 9'b011000000));
      tbl.push_back(mkv(8'b0_100_000_0, 9'b011011000));
      tbl.push_back(mkv(8'b1_100_000_0, 9'b011010000)); // 32 reset at beat 3
      tbl.push_back(mkv(8'b0_110_110_0, 9'b110000000));
      tbl.push_back(mkv(8'b0_110_110_0, 9'b011000000)); // 34 tie -> q0 again
      tbl.push_back(mkv(8'b0_000_000_0, 9'b011011000));

      for (int i = 0; i < tbl.size(); i++) begin
         logic [63:0] xd;
         logic [2:0]  xm;
         @(posedge clk_156m25); #1;
         reset_156m25 = tbl[i].rst;
         q0_val = tbl[i].v0; q0_sop = tbl[i].s0; q0_eop = tbl[i].e0;
         q1_val = tbl[i].v1; q1_sop = tbl[i].s1; q1_eop = tbl[i].e1;
         q0_data = {32'hA0A0A0A0, 32'(i)};
         q1_data = {32'hB1B1B1B1, 32'(i)};
         q0_mod = 3'd5; q1_mod = 3'd6;
         pkt_tx_full = tbl[i].ptf;
         @(negedge clk_156m25);
         xd = tbl[i].src ? {32'hB1B1B1B1, 32'(i - 1)} : {32'hA0A0A0A0, 32'(i - 1)};
         xm = tbl[i].tr ? 3'd0 : (tbl[i].src ? 3'd6 : 3'd5);
         chk($sformatf("row%0d q0_full", i), {63'd0, q0_full}, {63'd0, tbl[i].f0});
         chk($sformatf("row%0d q1_full", i), {63'd0, q1_full}, {63'd0, tbl[i].f1});
         chk($sformatf("row%0d busy", i), {63'd0, busy}, {63'd0, tbl[i].busy});
         chk($sformatf("row%0d val", i), {63'd0, pkt_tx_val}, {63'd0, tbl[i].val});
         chk($sformatf("row%0d trunc", i), {63'd0, trunc_pulse}, {63'd0, tbl[i].tr});
         if (tbl[i].busy) chk($sformatf("row%0d grant", i), {63'd0, grant_idx}, {63'd0, tbl[i].g});
         if (tbl[i].val) begin
            chk($sformatf("row%0d sop", i), {63'd0, pkt_tx_sop}, {63'd0, tbl[i].sop});
            chk($sformatf("row%0d eop", i), {63'd0, pkt_tx_eop}, {63'd0, tbl[i].eop});
            chk($sformatf("row%0d data", i), pkt_tx_data, xd);
            chk($sformatf("row%0d mod", i), {61'd0, pkt_tx_mod}, {61'd0, xm});
         end
      end
`else
      for (int i = 0; i < 24; i++) begin
         @(posedge clk_156m25); #1;
         reset_156m25 = 1'b0;
         q0_val = 1; q0_sop = 1; q0_eop = 1; q0_data = 64'h0000_0000_0000_0A0A;
         q1_val = 1; q1_sop = 1; q1_eop = 1; q1_data = 64'h8000_0000_0000_0B1B;
         @(negedge clk_156m25);
         chk($sformatf("prio%0d q1_full", i), {63'd0, q1_full}, 64'd1);
         if (pkt_tx_val) chk($sformatf("prio%0d port", i), {63'd0, pkt_tx_data[63]}, 64'd0);
      end
`endif

      // randomized traffic
      @(posedge clk_156m25); #1;
      reset_156m25 = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk_156m25);
      #1 reset_156m25 = 1'b0;
      for (int c = 0; c < 3300; c++) begin
         bit gen;
         gen = (c < 3000);
         @(posedge clk_156m25); #1;
         if (x0) begin src0.delete(0); accepted++; end
         if (x1) begin src1.delete(0); accepted++; end
         drive_srcs(gen);
         pkt_tx_full = gen ? ($urandom_range(0, 5) == 0) : 1'b0;
         @(negedge clk_156m25);
         check_out();
         x0 = q0_val & ~q0_full;
         x1 = q1_val & ~q1_full;
      end
      chk("src0_left", 64'(src0.size()), 64'd0);
      chk("src1_left", 64'(src1.size()), 64'd0);
      chk("exp0_left", 64'(exp0.size()), 64'd0);
      chk("exp1_left", 64'(exp1.size()), 64'd0);
      chk("beat_accounting", 64'(accepted), 64'(outs + dropped));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tx_queue_arb.md
TX_QUEUE_ARB -- requirements
Module: tx_queue_arb

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 1200, maximum 64-bit beats per packet before forced truncation (legal range 2..65535).
REQ-002 SHALL have ports:
- clk_156m25  in  1  sole clock; all logic on its rising edge
- reset_156m25  in  1  reset, synchronous and active-high
- q0_data / q1_data  in  64  packet data from source 0 / source 1
- q0_val, q0_sop, q0_eop / q1_*  in  1 each  beat valid, start of packet, end of packet
- q0_mod / q1_mod  in  3  valid bytes in eop beat (0 = all 8)
- q0_full / q1_full  out  1  backpressure to source; a beat transfers when qN_val=1 and qN_full=0
- pkt_tx_data  out  64  data to MAC transmit port
- pkt_tx_val, pkt_tx_sop, pkt_tx_eop  out  1 each  beat qualifiers to MAC
- pkt_tx_mod  out  3  byte count to MAC
- pkt_tx_full  in  1  MAC almost-full; at least 2 beats of margin
- trunc_pulse  out  1  one-cycle pulse when a packet is truncated
- grant_idx  out  1  port currently granted (valid when busy=1)
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL implement states IDLE, GRANT and DRAIN, with a grant index g and a last-served pointer lp.
REQ-004 A port SHALL be eligible when qN_val=1 and qN_sop=1; val without sop SHALL never be eligible.
REQ-005 IDLE->GRANT(g) SHALL occur when any port is eligible and pkt_tx_full=0; g chosen per REQ-006; lp<=g.
REQ-006 Arbitration SHALL be round-robin: if both ports are eligible, g = !lp; if one is eligible, g = that port.
REQ-007 qN_full SHALL be 0 only when state is GRANT or DRAIN, g=N and pkt_tx_full=0; otherwise 1 (both high in IDLE).
REQ-008 Each beat transferred in GRANT SHALL appear on pkt_tx_* exactly 1 cycle later; pkt_tx_val=0 on cycles with no transfer; data/sop/eop/mod are copied unmodified except per REQ-011.
REQ-009 On a transferred eop beat in GRANT: if the other port is eligible and pkt_tx_full=0, SHALL move directly to GRANT(other) with lp updated and no bubble; otherwise go to IDLE.
REQ-010 A beat counter SHALL clear on each grant and increment per transferred beat, saturating at MAX_BEATS.
REQ-011 When beat MAX_BEATS of a packet transfers without eop, it SHALL be output with pkt_tx_eop=1 and pkt_tx_mod=0, trunc_pulse SHALL pulse with that output beat, and state SHALL go to DRAIN.
REQ-012 In DRAIN, the source's beats SHALL be accepted (qN_full per REQ-007) and discarded (pkt_tx_val=0) up to and including its eop; the state then goes to IDLE.
REQ-013 A single-beat packet (sop=eop=1) SHALL be forwarded intact and handled per REQ-009 in the same cycle.
REQ-014 A sop arriving mid-packet in GRANT SHALL be forwarded unmodified; the arbiter takes no corrective action.
REQ-015 pkt_tx_full rising mid-packet SHALL stall transfers (qN_full=1) without changing state or counter.

Reset
REQ-016 While reset_156m25=1 at a clock edge: state=IDLE, lp=1 (port 0 wins first tie), counter=0, pkt_tx_val/sop/eop=0, pkt_tx_data=0, pkt_tx_mod=0, trunc_pulse=0, busy=0, grant_idx=0, q0_full=q1_full=1.
REQ-017 Reset mid-packet SHALL abort the packet with no eop emitted; recovery is the MAC's responsibility.

Configuration
REQ-018 Macro TXARB_STRICT_PRIO_EN: when defined, REQ-006 is replaced by fixed priority, with port 0 always winning when both are eligible and lp ignored. When undefined, round-robin per REQ-006 applies.

Verification
REQ-019 Both ports present 3-beat packets continuously (RR build) -> output alternates q0,q1,q0,q1 with no idle cycle between packets; data matches 1 cycle after transfer.
REQ-020 With TXARB_STRICT_PRIO_EN defined and both ports requesting continuously -> only q0 packets are output and q1_full stays 1.
REQ-021 MAX_BEATS=4; q1 sends a 7-beat packet -> output has 4 beats, the 4th with eop=1 and mod=0, trunc_pulse=1 once; q1 beats 5-7 are accepted and dropped, then IDLE.
REQ-022 pkt_tx_full=1 for 5 cycles during beat 2 of a q0 packet -> q0_full=1 for those cycles, no output beats, and the packet resumes intact.
REQ-023 Assert reset during beat 3 of a q0 packet -> next cycle all outputs are at reset values; the next tie is won by q0.
REQ-024 q1 presents val=1, sop=0 in IDLE while q0 is idle -> no grant, q1_full stays 1, busy=0.
